// File: rtl/wb_vga_capture.sv
// Captures a window of a VGA pixel stream and writes each pixel as one 32-bit word
// to memory over a pipelined Wishbone master, via a small pixel FIFO.
module wb_vga_capture #(
    parameter int ADDRESS_WIDTH  = 24,
    parameter int BITS_PER_COLOR = 8,
    parameter int LGFIFO         = 4
) (
    input  logic                      i_clk,
    input  logic                      i_reset_n,
    input  logic                      i_en,
    input  logic [ADDRESS_WIDTH-1:0]  i_base_addr,
    input  logic [ADDRESS_WIDTH-1:0]  i_line_words,
    input  logic [11:0]               i_h_skip,
    input  logic [11:0]               i_h_width,
    input  logic [11:0]               i_v_skip,
    input  logic [11:0]               i_v_height,
    input  logic                      i_vga_hsync,
    input  logic                      i_vga_vsync,
    input  logic [BITS_PER_COLOR-1:0] i_vga_red,
    input  logic [BITS_PER_COLOR-1:0] i_vga_grn,
    input  logic [BITS_PER_COLOR-1:0] i_vga_blu,
    output logic                      o_wb_cyc,
    output logic                      o_wb_stb,
    output logic                      o_wb_we,
    output logic [ADDRESS_WIDTH-1:0]  o_wb_addr,
    output logic [31:0]               o_wb_data,
    output logic [3:0]                o_wb_sel,
    input  logic                      i_wb_ack,
    input  logic                      i_wb_stall,
    input  logic                      i_wb_err,
    output logic                      o_interrupt,
    output logic                      o_overflow,
    output logic                      o_err
);
    localparam int AW    = ADDRESS_WIDTH;
    localparam int BPC   = BITS_PER_COLOR;
    localparam int CW    = 3 * BPC;
    localparam int EW    = 1 + AW + 32;
    localparam int DEPTH = 1 << LGFIFO;
    localparam int OW    = 16;

    typedef enum logic {ST_IDLE = 1'b0, ST_ARMED = 1'b1} cap_state_e;

    cap_state_e       state_q;
    logic             hs_q, hs_d1_q, vs_q, vs_d1_q, smp0_q, smp1_q;
    logic [BPC-1:0]   red_q, grn_q, blu_q;
    logic [11:0]      pix_cnt_q, line_cnt_q;
    logic             first_hs_q;
    logic [AW-1:0]    line_addr_q, stride_q;
    logic [11:0]      h_skip_q, h_width_q, v_skip_q, v_height_q;
    logic             ovf_q, err_q, cyc_q, last_pend_q, irq_q;
    logic [OW-1:0]    outst_q;
    logic [EW-1:0]    mem [DEPTH];
    logic [LGFIFO:0]  wptr_q, rptr_q;

    // Edges are only trusted once both sample stages hold post-reset values.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            hs_q <= 1'b0; hs_d1_q <= 1'b0; vs_q <= 1'b0; vs_d1_q <= 1'b0;
            smp0_q <= 1'b0; smp1_q <= 1'b0;
            red_q <= '0; grn_q <= '0; blu_q <= '0;
        end else begin
            hs_q <= i_vga_hsync; hs_d1_q <= hs_q;
            vs_q <= i_vga_vsync; vs_d1_q <= vs_q;
            smp0_q <= 1'b1; smp1_q <= smp0_q;
            red_q <= i_vga_red; grn_q <= i_vga_grn; blu_q <= i_vga_blu;
        end
    end

    logic frame_start, hs_rise, bus_err;
    assign frame_start = smp1_q & vs_q & ~vs_d1_q;
    assign hs_rise     = smp1_q & hs_q & ~hs_d1_q;
    assign bus_err     = cyc_q & i_wb_err;

    logic [11:0]   cur_pix, cur_line, line_inc, pix_next;
    logic [12:0]   h_end, v_end;
    logic          in_h, in_v, capture, line_end, last_px, empty, full, push, pop, stb;
    logic [AW-1:0] pix_addr;
    logic [CW-1:0] rgb;
    logic [31:0]   pixel_word;
    logic [EW-1:0] head;

    assign line_inc = (line_cnt_q == 12'hfff) ? line_cnt_q : line_cnt_q + 12'd1;
    assign cur_pix  = hs_rise ? 12'd0 : pix_cnt_q;
    assign cur_line = (hs_rise && !first_hs_q) ? line_inc : line_cnt_q;
    assign pix_next = (cur_pix == 12'hfff) ? cur_pix : cur_pix + 12'd1;
    assign h_end    = {1'b0, h_skip_q} + {1'b0, h_width_q};
    assign v_end    = {1'b0, v_skip_q} + {1'b0, v_height_q};
    assign in_h     = ({1'b0, cur_pix} >= {1'b0, h_skip_q}) && ({1'b0, cur_pix} < h_end);
    assign in_v     = ({1'b0, cur_line} >= {1'b0, v_skip_q}) && ({1'b0, cur_line} < v_end);
    assign capture  = i_en && (state_q == ST_ARMED) && in_h && in_v && hs_q && vs_q
                      && !frame_start && !bus_err;
    assign line_end = ({1'b0, cur_pix} == h_end - 13'd1);
    assign last_px  = line_end && ({1'b0, cur_line} == v_end - 13'd1);
    assign pix_addr = line_addr_q + AW'(cur_pix - h_skip_q);
    assign rgb        = {red_q, grn_q, blu_q};
    assign pixel_word = 32'(rgb);

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[LGFIFO] != rptr_q[LGFIFO]) &&
                   (wptr_q[LGFIFO-1:0] == rptr_q[LGFIFO-1:0]);
    assign push  = capture && !full;
    assign stb   = cyc_q && !empty;
    assign pop   = stb && !i_wb_stall;
    assign head  = mem[rptr_q[LGFIFO-1:0]];

    // Capture control: frame/line timing, windowing and the IDLE/ARMED state.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_IDLE;
            pix_cnt_q <= '0; line_cnt_q <= '0; first_hs_q <= 1'b1;
            line_addr_q <= '0; stride_q <= '0;
            h_skip_q <= '0; h_width_q <= '0; v_skip_q <= '0; v_height_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            pix_cnt_q <= pix_next;
            if (frame_start) begin
                line_cnt_q  <= '0;
                first_hs_q  <= 1'b1;
                line_addr_q <= i_base_addr;
                stride_q    <= i_line_words;
                h_skip_q    <= i_h_skip;
                h_width_q   <= i_h_width;
                v_skip_q    <= i_v_skip;
                v_height_q  <= i_v_height;
                if (i_en) ovf_q <= 1'b0;
            end else begin
                if (hs_rise) begin
                    first_hs_q <= 1'b0;
                    line_cnt_q <= cur_line;
                end
                if (capture && line_end) line_addr_q <= line_addr_q + stride_q;
                if (capture && full) ovf_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE:  if (frame_start && i_en) state_q <= ST_ARMED;
                ST_ARMED: if (!i_en || bus_err) state_q <= ST_IDLE;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) mem[wptr_q[LGFIFO-1:0]] <= {last_px, pix_addr, pixel_word};
    end

    // A bus error discards everything still queued.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wptr_q <= '0; rptr_q <= '0;
        end else if (bus_err) begin
            rptr_q <= wptr_q;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cyc_q <= 1'b0; outst_q <= '0; last_pend_q <= 1'b0;
            irq_q <= 1'b0; err_q <= 1'b0;
        end else begin
            irq_q <= 1'b0;
            if (bus_err) begin
                cyc_q <= 1'b0; outst_q <= '0; last_pend_q <= 1'b0; err_q <= 1'b1;
            end else begin
                if (frame_start && i_en) err_q <= 1'b0;
                if (!cyc_q) cyc_q <= !empty;
                else if (!stb && outst_q == '0) cyc_q <= 1'b0;
                case ({pop, cyc_q && i_wb_ack})
                    2'b10:   outst_q <= outst_q + 1'b1;
                    2'b01:   if (outst_q != '0) outst_q <= outst_q - 1'b1;
                    default: outst_q <= outst_q;
                endcase
                // The frame is done when the last-tagged write is the final one acknowledged.
                if (pop && head[EW-1]) last_pend_q <= 1'b1;
                else if (cyc_q && i_wb_ack && !pop && outst_q == OW'(1) && last_pend_q) begin
                    irq_q <= 1'b1;
                    last_pend_q <= 1'b0;
                end
            end
        end
    end

    assign o_wb_cyc    = cyc_q;
    assign o_wb_stb    = stb;
    assign o_wb_we     = cyc_q;
    assign o_wb_sel    = {4{cyc_q}};
    assign o_wb_addr   = stb ? head[EW-2 -: AW] : '0;
    assign o_wb_data   = stb ? head[31:0] : '0;
    assign o_interrupt = irq_q;
    assign o_overflow  = ovf_q;
    assign o_err       = err_q;
endmodule

// File: doc/wb_vga_capture.md
WB_VGA_CAPTURE -- requirements
Module: wb_vga_capture

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 24, meaning Wishbone word-address width (AW).
REQ-002 SHALL have parameter BITS_PER_COLOR, default 8, meaning bits per colour component (BPC); 3*BPC SHALL be at most 32.
REQ-003 SHALL have parameter LGFIFO, default 4, meaning log2 of pixel FIFO depth.
REQ-004 i_clk  in  1  sole clock; pixel sampling and bus operate on it; all logic rising-edge.
REQ-005 i_reset_n  in  1  asynchronous, active-low reset.
REQ-006 i_en  in  1  capture enable.
REQ-007 i_base_addr  in  AW  word address of first pixel of frame.
REQ-008 i_line_words  in  AW  word stride between captured lines.
REQ-009 i_h_skip, i_h_width, i_v_skip, i_v_height  in  12 each  pixels skipped/captured per line; lines skipped/captured per frame.
REQ-010 i_vga_hsync, i_vga_vsync  in  1 each  active-low sync inputs.
REQ-011 i_vga_red, i_vga_grn, i_vga_blu  in  BPC each  pixel colour.
REQ-012 o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  pipelined Wishbone master controls.
REQ-013 o_wb_addr  out  AW;  o_wb_data  out  32;  o_wb_sel  out  4.
REQ-014 i_wb_ack, i_wb_stall, i_wb_err  in  1 each  Wishbone responses.
REQ-015 o_interrupt  out  1  one-cycle frame-written pulse.
REQ-016 o_overflow, o_err  out  1 each  sticky FIFO-overflow and bus-error flags.

Function
REQ-017 Sync and colour inputs SHALL be registered once; all edge detection uses registered values.
REQ-018 Frame start = vsync deassertion (0->1): line counter:=0, line address:=i_base_addr, config latched.
REQ-019 Each hsync deassertion SHALL clear the pixel counter; line counter increments on each hsync deassertion after the first in the frame.
REQ-020 Pixel captured iff i_en, capture armed, v_skip <= line < v_skip+v_height, h_skip <= pixel < h_skip+h_width, and hsync and vsync both deasserted.
REQ-021 Capture states: IDLE -> ARMED at first frame start with i_en=1; ARMED -> IDLE on i_en=0 (takes effect immediately, no further pushes) or on bus error.
REQ-022 Captured pixel pushes FIFO entry {last, addr, pixel}; addr = line address + captured-pixel index; last=1 only for final pixel of final captured line.
REQ-023 After final captured pixel of each line, line address SHALL advance by i_line_words (AW-bit wrap-around).
REQ-024 Push while FIFO full SHALL drop the pixel and set o_overflow; o_overflow and o_err clear only at frame start with i_en=1, or on reset.
REQ-025 o_wb_data = {zero pad, red, grn, blu}; o_wb_sel=4'hf; o_wb_we=1 whenever o_wb_cyc.
REQ-026 Bus side: when FIFO non-empty raise cyc and stb with head entry; entry pops when stb && !stall; stb stays high while FIFO non-empty.
REQ-027 Outstanding-request counter increments on accepted stb, decrements on ack; same-cycle both leaves it unchanged.
REQ-028 cyc SHALL drop the cycle after stb low with zero outstanding; ack outside cyc ignored.
REQ-029 i_wb_err during cyc: cyc and stb drop next cycle, FIFO flushed, o_err set, capture returns IDLE.
REQ-030 When last-tagged write is acknowledged and outstanding reaches zero, o_interrupt SHALL pulse exactly one cycle.
REQ-031 i_h_width or i_v_height of 0: no pixels captured, no interrupt.

Reset
REQ-032 On i_reset_n low: all outputs 0, FIFO empty, counters 0, state IDLE, asynchronously.
REQ-033 Reset release SHALL not produce a frame start without an observed vsync 0->1 edge.

Verification
REQ-034 Frame h_skip=2,h_width=4,v_skip=1,v_height=2,base=0x100,stride=0x40, no stall -> 8 writes to 0x100-0x103, 0x140-0x143, one interrupt.
REQ-035 i_wb_stall held high 40 cycles with LGFIFO=4 and width 32 -> o_overflow=1, exactly 16 writes issued after release.
REQ-036 i_wb_err on third ack -> cyc low next cycle, o_err=1, no interrupt, no writes until next enabled frame.
REQ-037 i_en dropped mid-line -> no further pushes, queued writes complete, cyc drops, no interrupt.
REQ-038 Reset asserted mid-burst -> cyc/stb low immediately, FIFO empty; capture resumes only after next vsync edge.
